switch_debouncer: RTL and testbench
===================================

Name: switch_debouncer

Overview:
- Two-channel switch conditioner that sits directly upstream of the LED blinker.
- Takes the raw, asynchronous, bouncing board switches and synchronizes each one.
- Produces clean debounced levels that drive the blinker's two rate-select switch inputs.
- Also produces a ready flag; top level ANDs it into the blinker enable, so nothing blinks until both switch levels are trustworthy.

Parameters:
- c_debounce, 250000, consecutive stable clock cycles required before a new level is accepted (10 ms at 25 MHz); legal range >= 2; benches use 4.
- Counter width is derived as $clog2(c_debounce) and is not a parameter.

Ports:
- i_clock  input  1  system clock; all logic on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_switch_raw_1  input  1  raw board switch 1, asynchronous, may bounce.
- i_switch_raw_2  input  1  raw board switch 2, asynchronous, may bounce.
- o_switch_1  output  1  debounced level of switch 1; feeds blinker i_switch_1.
- o_switch_2  output  1  debounced level of switch 2; feeds blinker i_switch_2.
- o_ready  output  1  high once both channels have completed initial settling.
- o_change_1  output  1  present only with the optional feature; see below.
- o_change_2  output  1  present only with the optional feature; see below.

Behaviour:
- Reset (synchronous, i_reset high at a rising edge):
  - Synchronizer flops = 0, counters = 0, channel state = INIT.
  - o_switch_1/2 = 0, o_ready = 0, o_change_1/2 = 0.
  - Reset wins over every other event in the same cycle, including mid-settling; the partial count is discarded.
- Synchronizer: each raw input passes through a 2-flop chain (s1 then s2). Only s2 is used downstream.
- Per-channel FSM, states INIT / STABLE / SETTLING; d is the registered debounced level, cnt the counter.
  - INIT:
    - If s2 differs from the previous s2, cnt <= 0.
    - Otherwise, if cnt == c_debounce-1: d <= s2, cnt <= 0, go to STABLE.
    - Otherwise cnt <= cnt+1.
  - STABLE:
    - If s2 != d: cnt <= 1, go to SETTLING.
    - Otherwise hold, cnt = 0.
  - SETTLING:
    - If s2 == d (bounce back): cnt <= 0, go to STABLE; d is unchanged.
    - Else if cnt == c_debounce-1: d <= s2, cnt <= 0, go to STABLE.
    - Else cnt <= cnt+1.
- Latency:
  - A raw level change held steady is first captured by s1 on edge 1.
  - o_switch updates on rising edge c_debounce+2; with c_debounce=4 that is edge 6.
  - Any mismatch run shorter than c_debounce cycles at s2, including exactly c_debounce-1, produces no output change.
- Counter never exceeds c_debounce-1; there is no wrap-around path.
- o_ready: registered; rises the cycle after both channels have left INIT. Once high it stays high until reset.
- Channels are fully independent. Simultaneous transitions on both channels update both outputs on the same edge.
- Outputs are registered; there is no combinational path from raw inputs to outputs.

Optional Feature:
- Macro DEBOUNCE_CHANGE_PULSE_EN.
- Defined:
  - Adds ports o_change_1 and o_change_2.
  - Each pulses high for exactly one cycle on the same edge its d toggles on a SETTLING -> STABLE acceptance.
  - No pulse on INIT completion, on bounce-back, or during reset.
- Undefined: the ports and pulse logic are absent. All other behaviour is identical.

Decomposition:
- Shared package holds:
  - the channel state encoding: INIT=2'd0, STABLE=2'd1, SETTLING=2'd2;
  - the default debounce constant.
- One sub-module is natural: debounce_channel, which holds the synchronizer, FSM, counter and optional change pulse.
- switch_debouncer instantiates debounce_channel twice and generates o_ready.

Test Plan:
- Reset, raw inputs both 1 held steady, c_debounce=4 -> o_switch_1/2 = 0 until INIT completes, then 1 with o_ready = 1; o_ready stays 0 until then.
- From STABLE 0, raw_1 goes 1 and is held -> o_switch_1 rises on edge 6 after the change; with macro defined, o_change_1 is high for exactly that one cycle.
- raw_2 glitches high for 3 cycles then returns to 0 -> o_switch_2 stays 0 and o_change_2 never pulses.
- raw_1 bounces 1,0,1,0 every cycle for 10 cycles, then holds 1 -> o_switch_1 rises exactly 6 edges after the final transition.
- Both raw inputs change together -> o_switch_1 and o_switch_2 update on the same edge.
- i_reset asserted for 1 cycle mid-SETTLING -> outputs return to 0 and o_ready to 0 on that edge; full INIT is re-run before o_ready reasserts.

Source files
------------

// File: rtl/switch_debouncer_pkg.sv
// switch_debouncer_pkg: channel state encoding and default debounce length shared by the debouncer files.
package switch_debouncer_pkg;

   typedef enum logic [1:0] {
      ST_INIT     = 2'd0,
      ST_STABLE   = 2'd1,
      ST_SETTLING = 2'd2
   } chan_state_e;

   // 10 ms of required stability at a 25 MHz system clock
   localparam int C_DEBOUNCE_DEFAULT = 250000;

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: 2-flop synchronizer plus INIT/STABLE/SETTLING debounce FSM for one switch;
// DEBOUNCE_CHANGE_PULSE_EN adds a one-cycle o_change pulse on each accepted level toggle.
module debounce_channel
   import switch_debouncer_pkg::*;
#(
   parameter int c_debounce = C_DEBOUNCE_DEFAULT
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_raw,
   output logic o_level,
   output logic o_settled
`ifdef DEBOUNCE_CHANGE_PULSE_EN
   ,
   output logic o_change
`endif
);

   localparam int CW = $clog2(c_debounce);
   localparam logic [CW-1:0] CNT_MAX = CW'(c_debounce - 1);

   logic          s1_q, s1_d;
   logic          s2_q, s2_d;
   logic          s3_q, s3_d;
   logic          level_q, level_d;
   logic [CW-1:0] cnt_q, cnt_d;
   chan_state_e   state_q, state_d;

   // synchronizer chain plus one extra tap of s2 so INIT can see whether s2 just moved
   always_comb begin
      s1_d = i_raw;
      s2_d = s1_q;
      s3_d = s2_q;
   end

   // next-state, counter and debounced level; counter is capped at CNT_MAX by construction
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      case (state_q)
         ST_INIT: begin
            if (s2_q != s3_q) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
               level_d = s2_q;
               cnt_d   = '0;
               state_d = ST_STABLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_STABLE: begin
            cnt_d   = (s2_q != level_q) ? CW'(1) : '0;
            state_d = (s2_q != level_q) ? ST_SETTLING : ST_STABLE;
         end
         ST_SETTLING: begin
            if (s2_q == level_q) begin
               cnt_d   = '0;
               state_d = ST_STABLE;
            end else if (cnt_q == CNT_MAX) begin
               level_d = s2_q;
               cnt_d   = '0;
               state_d = ST_STABLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_INIT;
         end
      endcase
   end

   // state register; reset discards any partial count and restarts initial settling
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         s3_q    <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
         state_q <= ST_INIT;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         s3_q    <= s3_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
      end
   end

   assign o_level   = level_q;
   assign o_settled = (state_q != ST_INIT);

`ifdef DEBOUNCE_CHANGE_PULSE_EN
   logic change_q, change_d;

   // pulse only when a SETTLING run is accepted, never on INIT completion or bounce-back
   always_comb begin
      change_d = (state_q == ST_SETTLING) && (s2_q != level_q) && (cnt_q == CNT_MAX);
   end

   // register the pulse so it coincides with the edge that toggles the level
   always_ff @(posedge i_clock) begin
      if (i_reset) change_q <= 1'b0;
      else         change_q <= change_d;
   end

   assign o_change = change_q;
`endif

endmodule

// File: rtl/switch_debouncer.sv
// switch_debouncer: two independent debounced switch channels plus a sticky ready flag;
// DEBOUNCE_CHANGE_PULSE_EN adds o_change_1/o_change_2 acceptance pulses.
module switch_debouncer
   import switch_debouncer_pkg::*;
#(
   parameter int c_debounce = C_DEBOUNCE_DEFAULT
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_switch_raw_1,
   input  logic i_switch_raw_2,
   output logic o_switch_1,
   output logic o_switch_2,
   output logic o_ready
`ifdef DEBOUNCE_CHANGE_PULSE_EN
   ,
   output logic o_change_1,
   output logic o_change_2
`endif
);

   logic settled_1, settled_2;
   logic ready_q, ready_d;

   debounce_channel #(.c_debounce(c_debounce)) u_ch1 (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_raw    (i_switch_raw_1),
      .o_level  (o_switch_1),
      .o_settled(settled_1)
`ifdef DEBOUNCE_CHANGE_PULSE_EN
      ,
      .o_change (o_change_1)
`endif
   );

   debounce_channel #(.c_debounce(c_debounce)) u_ch2 (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_raw    (i_switch_raw_2),
      .o_level  (o_switch_2),
      .o_settled(settled_2)
`ifdef DEBOUNCE_CHANGE_PULSE_EN
      ,
      .o_change (o_change_2)
`endif
   );

   // ready latches once both channels have left INIT and holds until reset
   always_comb begin
      ready_d = ready_q | (settled_1 & settled_2);
   end

   // ready register
   always_ff @(posedge i_clock) begin
      if (i_reset) ready_q <= 1'b0;
      else         ready_q <= ready_d;
   end

   assign o_ready = ready_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: directed plus random stimulus checked against a run-length reference model.
module tb_switch_debouncer;
   localparam int C = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic raw1 = 1'b0, raw2 = 1'b0;
   logic sw1, sw2, rdy;
`ifdef DEBOUNCE_CHANGE_PULSE_EN
   logic chg1, chg2;
`endif

   switch_debouncer #(.c_debounce(C)) dut (
      .i_clock       (clk),
      .i_reset       (rst),
      .i_switch_raw_1(raw1),
      .i_switch_raw_2(raw2),
      .o_switch_1    (sw1),
      .o_switch_2    (sw2),
      .o_ready       (rdy)
`ifdef DEBOUNCE_CHANGE_PULSE_EN
      ,
      .o_change_1    (chg1),
      .o_change_2    (chg2)
`endif
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: synchronizer pipeline and run lengths of stable / mismatching samples
   bit m_s1[2], m_s2[2], m_prev[2], m_done[2], m_d[2], m_chg[2];
   bit m_ready;
   int m_run[2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input bit r1, input bit r2, input bit rs);
      bit r[2];
      bit both;
      r[0] = r1;
      r[1] = r2;
      if (rs) begin
         for (int i = 0; i < 2; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_prev[i] = 0; m_done[i] = 0;
            m_d[i] = 0; m_chg[i] = 0; m_run[i] = 0;
         end
         m_ready = 0;
      end else begin
         both = m_done[0] & m_done[1];
         for (int i = 0; i < 2; i++) begin
            m_chg[i] = 0;
            if (!m_done[i]) begin
               m_run[i] = (m_s2[i] == m_prev[i]) ? m_run[i] + 1 : 0;
               if (m_run[i] == C) begin
                  m_done[i] = 1; m_d[i] = m_s2[i]; m_run[i] = 0;
               end
            end else begin
               m_run[i] = (m_s2[i] != m_d[i]) ? m_run[i] + 1 : 0;
               if (m_run[i] == C) begin
                  m_d[i] = m_s2[i]; m_run[i] = 0; m_chg[i] = 1;
               end
            end
            m_prev[i] = m_s2[i];
            m_s2[i]   = m_s1[i];
            m_s1[i]   = r[i];
         end
         m_ready = m_ready | both;
      end
   endtask

   task automatic tick(input bit r1, input bit r2, input bit rs);
      raw1 = r1;
      raw2 = r2;
      rst  = rs;
      @(posedge clk);
      model_step(r1, r2, rs);
      @(negedge clk);
      check("sw1", {31'd0, sw1}, {31'd0, m_d[0]});
      check("sw2", {31'd0, sw2}, {31'd0, m_d[1]});
      check("ready", {31'd0, rdy}, {31'd0, m_ready});
`ifdef DEBOUNCE_CHANGE_PULSE_EN
      check("chg1", {31'd0, chg1}, {31'd0, m_chg[0]});
      check("chg2", {31'd0, chg2}, {31'd0, m_chg[1]});
`endif
   endtask

   initial begin
      bit l1, l2, rs;
      // reset then both raw inputs held at 1 through initial settling
      tick(1, 1, 1);
      tick(1, 1, 1);
      check("rst_sw1", {31'd0, sw1}, 32'd0);
      check("rst_ready", {31'd0, rdy}, 32'd0);
      for (int i = 0; i < 12; i++) tick(1, 1, 0);
      check("init_sw1", {31'd0, sw1}, 32'd1);
      check("init_sw2", {31'd0, sw2}, 32'd1);
      check("init_ready", {31'd0, rdy}, 32'd1);
      // settle both to 0, then raw_1 rises and is held: output moves on edge 6
      for (int i = 0; i < 10; i++) tick(0, 0, 0);
      for (int i = 1; i <= 6; i++) begin
         tick(1, 0, 0);
         if (i == 5) check("lat5_sw1", {31'd0, sw1}, 32'd0);
      end
      check("lat6_sw1", {31'd0, sw1}, 32'd1);
      // raw_2 glitch of 3 cycles is rejected
      for (int i = 0; i < 3; i++) tick(1, 1, 0);
      for (int i = 0; i < 8; i++) tick(1, 0, 0);
      check("glitch_sw2", {31'd0, sw2}, 32'd0);
      // bounce raw_1 for 10 cycles then hold 1
      for (int i = 0; i < 8; i++) tick(0, 0, 0);
      for (int i = 0; i < 10; i++) tick(bit'((i & 1) == 0), 0, 0);
      for (int i = 1; i <= 8; i++) begin
         tick(1, 0, 0);
         if (i == 5) check("bounce5_sw1", {31'd0, sw1}, 32'd0);
         if (i == 6) check("bounce6_sw1", {31'd0, sw1}, 32'd1);
      end
      // both channels change together
      for (int i = 1; i <= 8; i++) begin
         tick(0, 1, 0);
         if (i == 5) check("both5", {30'd0, sw1, sw2}, 32'd2);
         if (i == 6) check("both6", {30'd0, sw1, sw2}, 32'd1);
      end
      // reset in the middle of settling
      for (int i = 0; i < 3; i++) tick(1, 0, 0);
      tick(1, 0, 1);
      check("midrst_sw2", {31'd0, sw2}, 32'd0);
      check("midrst_ready", {31'd0, rdy}, 32'd0);
      for (int i = 0; i < 4; i++) tick(1, 0, 0);
      check("rerun_ready", {31'd0, rdy}, 32'd0);
      for (int i = 0; i < 10; i++) tick(1, 0, 0);
      check("rerun_ready2", {31'd0, rdy}, 32'd1);
      // random bouncing with occasional resets
      l1 = 0;
      l2 = 0;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 11) == 0) l1 = ~l1;
         if ($urandom_range(0, 11) == 0) l2 = ~l2;
         rs = ($urandom_range(0, 399) == 0);
         tick($urandom_range(0, 5) == 0 ? ~l1 : l1, $urandom_range(0, 5) == 0 ? ~l2 : l2, rs);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
